// File: rtl/imem_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : imem_arbiter_if
// Description : Requester and memory-side bus bundle for imem_arbiter.
//               slave  = arbiter view, master = environment view.
// Revision    : 1.0 - initial release
// ============================================================================
interface imem_arbiter_if #(
  parameter int IDX_W = 6
);
  // port 0: instruction fetch (read-only)
  logic             req0;
  logic [31:0]      addr0;
  logic             gnt0;
  logic             rvalid0;
  logic [31:0]      rdata0;
  logic             err0;
  // port 1: data / loader (read-write)
  logic             req1;
  logic             we1;
  logic [3:0]       be1;
  logic [31:0]      addr1;
  logic [31:0]      wdata1;
  logic             gnt1;
  logic             rvalid1;
  logic [31:0]      rdata1;
  logic             err1;
  // memory side
  logic             mem_en;
  logic [3:0]       mem_we;
  logic [IDX_W-1:0] mem_addr;
  logic [31:0]      mem_wdata;
  logic [31:0]      mem_rdata;

  modport slave (
    input  req0, addr0, req1, we1, be1, addr1, wdata1, mem_rdata,
    output gnt0, rvalid0, rdata0, err0, gnt1, rvalid1, rdata1, err1,
           mem_en, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output req0, addr0, req1, we1, be1, addr1, wdata1, mem_rdata,
    input  gnt0, rvalid0, rdata0, err0, gnt1, rvalid1, rdata1, err1,
           mem_en, mem_we, mem_addr, mem_wdata
  );
endinterface
`default_nettype wire

// File: rtl/imem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : imem_arbiter
// Description : Two-port round-robin arbiter in front of a single-port,
//               synchronous-read, word-organised program memory. Port 0 is
//               instruction fetch, port 1 is data/loader. One access per
//               cycle, one-cycle response latency, address error checking.
// Revision    : 1.0 - initial release
// ============================================================================
module imem_arbiter #(
  parameter int DEPTH = 55,
  parameter int IDX_W = 6
) (
  input  logic              clk,
  input  logic              reset,
  imem_arbiter_if.slave     bus
);

  localparam logic [29:0] DEPTH_W = 30'(DEPTH);

  // arbitration state: index of the port granted most recently
  logic             last_grant;

  // response pipeline stage
  logic             resp_valid;
  logic             resp_port;
  logic             resp_write;
  logic             resp_err;

  // last issued command, kept on idle cycles so the memory bus stays quiet
  logic [IDX_W-1:0] addr_hold;
  logic [31:0]      wdata_hold;

  // combinational request path
  logic             gnt0_c;
  logic             gnt1_c;
  logic             any_gnt;
  logic [31:0]      sel_addr;
  logic             sel_write;
  logic             addr_err;
  logic [IDX_W-1:0] idx;
  logic             access_ok;

  // Grant, address decode and error check for the winning request
  always_comb begin
    gnt0_c    = 1'b0;
    gnt1_c    = 1'b0;
    any_gnt   = 1'b0;
    sel_addr  = 32'd0;
    sel_write = 1'b0;
    addr_err  = 1'b0;
    idx       = '0;
    access_ok = 1'b0;
    if (!reset) begin
      gnt0_c = bus.req0 & (~bus.req1 | last_grant);
      gnt1_c = bus.req1 & (~bus.req0 | ~last_grant);
    end
    any_gnt   = gnt0_c | gnt1_c;
    sel_addr  = gnt1_c ? bus.addr1 : bus.addr0;
    sel_write = gnt1_c & bus.we1;
    // misaligned or beyond the last word: never reaches the memory
    addr_err  = (sel_addr[1:0] != 2'b00) || (sel_addr[31:2] >= DEPTH_W);
    idx       = sel_addr[IDX_W+1:2];
    access_ok = any_gnt & ~addr_err;
  end

  // Grant outputs and memory command, all suppressed while in reset
  always_comb begin
    bus.gnt0      = gnt0_c;
    bus.gnt1      = gnt1_c;
    bus.mem_en    = access_ok;
    bus.mem_we    = (access_ok & sel_write) ? bus.be1 : 4'b0000;
    bus.mem_addr  = addr_hold;
    bus.mem_wdata = wdata_hold;
    if (reset) begin
      bus.mem_addr  = '0;
      bus.mem_wdata = 32'd0;
    end else if (any_gnt) begin
      bus.mem_addr  = idx;
      bus.mem_wdata = bus.wdata1;
    end
  end

  // Round-robin pointer; port 0 wins the first contention after reset
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_grant <= 1'b1;
    end else if (any_gnt) begin
      last_grant <= gnt1_c;
    end
  end

  // Hold the last issued index and write data across idle cycles
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      addr_hold  <= '0;
      wdata_hold <= 32'd0;
    end else if (any_gnt) begin
      addr_hold  <= idx;
      wdata_hold <= bus.wdata1;
    end
  end

  // Response stage: captures who was granted and how the access resolved
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      resp_valid <= 1'b0;
      resp_port  <= 1'b0;
      resp_write <= 1'b0;
      resp_err   <= 1'b0;
    end else begin
      resp_valid <= any_gnt;
      if (any_gnt) begin
        resp_port  <= gnt1_c;
        resp_write <= sel_write;
        resp_err   <= addr_err;
      end
    end
  end

  // Steer the response to its owner; data only for successful reads
  always_comb begin
    bus.rvalid0 = resp_valid & ~resp_port;
    bus.rvalid1 = resp_valid & resp_port;
    bus.err0    = bus.rvalid0 & resp_err;
    bus.err1    = bus.rvalid1 & resp_err;
    bus.rdata0  = 32'd0;
    bus.rdata1  = 32'd0;
    if (bus.rvalid0 && !resp_err && !resp_write) begin
      bus.rdata0 = bus.mem_rdata;
    end
    if (bus.rvalid1 && !resp_err && !resp_write) begin
      bus.rdata1 = bus.mem_rdata;
    end
  end

endmodule
`default_nettype wire

// File: doc/imem_arbiter.md
Name: imem_arbiter

Overview:
- Shares one single-port, word-organised instruction/program memory between two requesters.
  - Port 0: instruction fetch, read-only.
  - Port 1: data/loader, read and write.
- Converts byte addresses to word indices and arbitrates round-robin on contention.
- Issues at most one memory access per cycle and returns a one-cycle-latency response to the granted requester.
- Sits between the core's fetch/load-store paths and the synchronous-read memory array.

Parameters:
- DEPTH, 55, number of 32-bit words in the memory; valid word indices 0..DEPTH-1.
- IDX_W, 6, width of the word index to memory; must satisfy 2^IDX_W >= DEPTH.

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- req0  input  1  port 0 read request.
- addr0  input  32  port 0 byte address.
- gnt0  output  1  port 0 request accepted this cycle.
- rvalid0  output  1  port 0 response valid.
- rdata0  output  32  port 0 read data.
- err0  output  1  port 0 access error, qualified by rvalid0.
- req1  input  1  port 1 request.
- we1  input  1  port 1 write enable, 1 = write.
- be1  input  4  port 1 byte enables for writes.
- addr1  input  32  port 1 byte address.
- wdata1  input  32  port 1 write data.
- gnt1  output  1  port 1 request accepted this cycle.
- rvalid1  output  1  port 1 response valid; write acknowledge for writes.
- rdata1  output  32  port 1 read data; 0 for writes.
- err1  output  1  port 1 access error, qualified by rvalid1.
- mem_en  output  1  memory access strobe.
- mem_we  output  4  memory byte write strobes.
- mem_addr  output  IDX_W  memory word index.
- mem_wdata  output  32  memory write data.
- mem_rdata  input  32  memory read data, valid the cycle after mem_en.

Behaviour:
- Reset (asynchronous, immediate):
  - rvalid0/1 = 0, rdata0/1 = 0, err0/1 = 0.
  - last_grant = 1, so port 0 wins the first contention.
  - Pending response discarded.
  - gnt/mem_* outputs are combinational and forced to 0 while reset is high.
- Grant (combinational, same cycle as request):
  - gnt0 = req0 & (!req1 | last_grant==1).
  - gnt1 = req1 & (!req0 | last_grant==0).
  - Exactly one grant on contention; never both.
- last_grant updates on every grant to the granted port index; it holds when no grant.
- Requesters hold req/addr/data stable until their gnt is seen; a request deasserted before gnt is simply dropped.
- Address check for the granted request:
  - err if addr[1:0] != 0, or addr[31:2] >= DEPTH.
  - Index = addr[IDX_W+1:2].
- Memory command, same cycle as the grant:
  - OK request: mem_en = 1, mem_addr = index, mem_we = (port1 & we1) ? be1 : 0, mem_wdata = wdata1.
  - Erroring request: mem_en = 0, mem_we = 0, so memory is never touched.
  - No grant: mem_en = 0, mem_we = 0; mem_addr/mem_wdata hold the last value (don't care).
- Response pipeline register (port id, is_write, err, valid), loaded on each grant.
- Next cycle, the granted port sees rvalidX = 1:
  - rdataX = mem_rdata for an OK read.
  - rdataX = 0 for a write or any error.
  - errX = stored err.
- The non-granted port's rvalid stays 0.
- rvalid is a 1-cycle pulse; no backpressure on responses.
- Throughput: one grant per cycle, back-to-back accepted; response N overlaps grant N+1.
- A write ack does not require mem_rdata.
- Reset mid-operation:
  - An in-flight response never appears after reset deasserts.
  - The first grant after reset follows the reset priority (port 0).
- be1 = 0 on a write: still granted and acked, err = 0, mem_we = 0.

Test Plan:
- Single fetch: req0, addr0 = 0x8 -> gnt0 same cycle, mem_en = 1, mem_addr = 2. Next cycle rvalid0 = 1, rdata0 = mem_rdata (preload 0xDEADBEEF), err0 = 0.
- Contention after reset: req0 = req1 = 1 held 4 cycles -> grants alternate 0,1,0,1. Each rvalid pulses on the correct port the following cycle.
- Write then read: port 1 writes wdata1 = 0x12345678, be1 = 4'b0011, addr 0xC -> mem_we = 4'b0011, mem_addr = 3, rvalid1 with rdata1 = 0. Following read of 0xC returns model contents 0x????5678 per byte-strobe model.
- Errors:
  - addr0 = 0x6 -> gnt0 = 1, mem_en = 0, next cycle rvalid0 = 1, err0 = 1, rdata0 = 0.
  - addr1 = 4*DEPTH (0xDC) -> same on port 1.
- Back-to-back: req0 every cycle, addrs 0, 4, 8, 12 -> four consecutive grants and four consecutive rvalid0 pulses with matching data.
- Reset mid-operation: assert reset one cycle after a grant -> rvalid0/1 stay 0 throughout. After release, contention grants port 0 first.
